// File: rtl/tx_audio_sequencer.sv
// Audio sample sequencer for the FM transmitter: sample-rate strobe, per-strobe
// source selection, linear start/stop gain ramp and a two-stage scaling pipeline.
module tx_audio_sequencer #(
  parameter int WIDTH      = 16,
  parameter int RATE       = 4500,
  parameter int RAMP_SHIFT = 8
) (
  input  logic                    clk_216,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [1:0]              src_sel,
  input  logic signed [WIDTH-1:0] ext_data,
  input  logic                    ext_valid,
  output logic                    ext_ready,
  output logic signed [WIDTH-1:0] data_out,
  output logic                    stb_out,
  output logic                    busy,
  output logic [1:0]              state_o,
  output logic [15:0]             underflow_cnt
);
  localparam int CNT_W  = (RATE > 1) ? $clog2(RATE) : 1;
  localparam int PROD_W = WIDTH + RAMP_SHIFT + 2;
  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(RATE - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
  localparam logic [RAMP_SHIFT:0] GAIN_FULL = {1'b1, {RAMP_SHIFT{1'b0}}};
  localparam logic [RAMP_SHIFT:0] GAIN_ONE  = (RAMP_SHIFT + 1)'(1);
  localparam logic [4:0]          LUT_LAST  = 5'd19;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [RAMP_SHIFT:0]     gain;
  logic [RAMP_SHIFT:0]     gain_next;
  logic [4:0]              idx;
  logic signed [WIDTH-1:0] last_sample;
  logic signed [WIDTH-1:0] sample_sel;
  logic                    tick;

  logic signed [WIDTH-1:0] sample_p1;
  logic [RAMP_SHIFT:0]     gain_p1;
  logic                    vld_p1;

  function automatic logic signed [15:0] sine_lut(input logic [4:0] i);
    case (i)
      5'd0:    sine_lut = 16'sh0000;
      5'd1:    sine_lut = 16'sh278E;
      5'd2:    sine_lut = 16'sh4B3C;
      5'd3:    sine_lut = 16'sh678D;
      5'd4:    sine_lut = 16'sh79BB;
      5'd5:    sine_lut = 16'sh7FFF;
      5'd6:    sine_lut = 16'sh79BB;
      5'd7:    sine_lut = 16'sh678D;
      5'd8:    sine_lut = 16'sh4B3C;
      5'd9:    sine_lut = 16'sh278E;
      5'd10:   sine_lut = 16'sh0000;
      5'd11:   sine_lut = 16'shD872;
      5'd12:   sine_lut = 16'shB4C4;
      5'd13:   sine_lut = 16'sh9873;
      5'd14:   sine_lut = 16'sh8645;
      5'd15:   sine_lut = 16'sh8001;
      5'd16:   sine_lut = 16'sh8645;
      5'd17:   sine_lut = 16'sh9873;
      5'd18:   sine_lut = 16'shB4C4;
      5'd19:   sine_lut = 16'shD872;
      default: sine_lut = 16'sh0000;
    endcase
  endfunction

  // Gain never exceeds 2^RAMP_SHIFT, so the floored shift always fits WIDTH bits.
  function automatic logic signed [WIDTH-1:0] scale(input logic signed [WIDTH-1:0] s,
                                                     input logic [RAMP_SHIFT:0]     g);
    logic signed [PROD_W-1:0] sx;
    logic signed [PROD_W-1:0] gx;
    logic signed [PROD_W-1:0] prod;
    sx   = PROD_W'(s);
    gx   = PROD_W'($signed({1'b0, g}));
    prod = sx * gx;
    return WIDTH'(prod >>> RAMP_SHIFT);
  endfunction

  assign tick      = (cnt == CNT_LAST) && (state != IDLE);
  assign ext_ready = tick && (src_sel == 2'd1);
  assign busy      = (state != IDLE);
  assign state_o   = state;

  always_comb begin
    gain_next = gain;
    if (tick) begin
      case (state)
        RAMP_UP:   gain_next = (gain >= GAIN_FULL) ? GAIN_FULL : gain + GAIN_ONE;
        RAMP_DOWN: gain_next = (gain == '0) ? '0 : gain - GAIN_ONE;
        default:   gain_next = gain;
      endcase
    end
    case (src_sel)
      2'd0:    sample_sel = WIDTH'(sine_lut(idx));
      2'd1:    sample_sel = ext_valid ? ext_data : last_sample;
      default: sample_sel = '0;
    endcase
  end

  always_ff @(posedge clk_216) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      gain          <= '0;
      idx           <= '0;
      last_sample   <= '0;
      underflow_cnt <= '0;
    end else begin
      cnt  <= (state == IDLE || tick) ? '0 : cnt + CNT_ONE;
      gain <= gain_next;
      case (state)
        IDLE: if (enable) begin
          state         <= RAMP_UP;
          idx           <= '0;
          underflow_cnt <= '0;
        end
        RAMP_UP:
          if (!enable)                             state <= RAMP_DOWN;
          else if (tick && gain_next == GAIN_FULL) state <= RUN;
        RUN:
          if (!enable) state <= RAMP_DOWN;
        RAMP_DOWN:
          if (enable)                              state <= RAMP_UP;
          else if (tick && gain_next == '0)        state <= IDLE;
        default: state <= IDLE;
      endcase
      if (tick) begin
        case (src_sel)
          2'd0: idx <= (idx == LUT_LAST) ? '0 : idx + 5'd1;
          2'd1:
            if (ext_valid)                      last_sample   <= ext_data;
            else if (underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
          default: ;
        endcase
      end
    end
  end

  // Stage 1: capture selected sample and post-update gain on tick
  always_ff @(posedge clk_216) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      sample_p1 <= '0;
      gain_p1   <= '0;
    end else begin
      vld_p1 <= tick;
      if (tick) begin
        sample_p1 <= sample_sel;
        gain_p1   <= gain_next;
      end
    end
  end

  // Stage 2: scaled output and strobe
  always_ff @(posedge clk_216) begin
    if (rst) begin
      stb_out  <= 1'b0;
      data_out <= '0;
    end else begin
      stb_out <= vld_p1;
      if (vld_p1) data_out <= scale(sample_p1, gain_p1);
    end
  end
endmodule

// File: tb/tb_tx_audio_sequencer.sv
// Directed bench for tx_audio_sequencer at RATE=8, RAMP_SHIFT=2: per-strobe vector
// table plus a hand-written mid-run reset sequence.
module tb_tx_audio_sequencer;
  localparam int WIDTH      = 16;
  localparam int RATE       = 8;
  localparam int RAMP_SHIFT = 2;
  localparam int NVEC       = 24;

  logic        clk_216 = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  src_sel = 2'd0;
  logic [15:0] ext_data = 16'h0;
  logic        ext_valid = 1'b0;
  logic        ext_ready;
  logic [15:0] data_out;
  logic        stb_out;
  logic        busy;
  logic [1:0]  state_o;
  logic [15:0] underflow_cnt;

  tx_audio_sequencer #(.WIDTH(WIDTH), .RATE(RATE), .RAMP_SHIFT(RAMP_SHIFT)) dut (
    .clk_216      (clk_216),
    .rst          (rst),
    .enable       (enable),
    .src_sel      (src_sel),
    .ext_data     (ext_data),
    .ext_valid    (ext_valid),
    .ext_ready    (ext_ready),
    .data_out     (data_out),
    .stb_out      (stb_out),
    .busy         (busy),
    .state_o      (state_o),
    .underflow_cnt(underflow_cnt)
  );

  always #5 clk_216 = ~clk_216;

  typedef struct {
    bit          rst_first;
    bit          en;
    logic [1:0]  src;
    logic [15:0] xd;
    bit          xv;
    logic [15:0] exp_data;
    logic [1:0]  exp_state;
    logic [15:0] exp_uf;
    bit          idle_after;
  } vec_t;

  vec_t vecs[NVEC];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h, required %h", name, act, exp);
    end
  endtask

  task automatic wait_strobe(output int cyc, output int rdy_n, output int rdy_at);
    cyc    = 0;
    rdy_n  = 0;
    rdy_at = -1;
    do begin
      @(negedge clk_216);
      cyc++;
      if (ext_ready) begin
        rdy_n++;
        rdy_at = cyc;
      end
    end while (!stb_out && cyc < 40);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, rdy_n, rdy_at, stb_seen;

    // rst, en, src, ext_data, ext_valid, expected data, state, underflow, idle check
    vecs[0]  = '{1'b1, 1'b1, 2'd0, 16'h0000, 1'b0, 16'h0000, 2'd1, 16'd0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 2'd0, 16'h0000, 1'b0, 16'h13C7, 2'd1, 16'd0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 2'd0, 16'h0000, 1'b0, 16'h386D, 2'd1, 16'd0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 2'd0, 16'h0000, 1'b0, 16'h678D, 2'd2, 16'd0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 2'd0, 16'h0000, 1'b0, 16'h79BB, 2'd2, 16'd0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 2'd0, 16'h0000, 1'b0, 16'h7FFF, 2'd2, 16'd0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 16'h5B4C, 2'd3, 16'd0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 16'h33C6, 2'd3, 16'd0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 16'h12CF, 2'd3, 16'd0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 16'h0000, 2'd0, 16'd0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 2'd1, 16'h8001, 1'b1, 16'hE000, 2'd1, 16'd0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 2'd1, 16'h1234, 1'b1, 16'h091A, 2'd1, 16'd0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 2'd1, 16'h5555, 1'b0, 16'h0DA7, 2'd1, 16'd1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 2'd1, 16'h8000, 1'b1, 16'h8000, 2'd2, 16'd1, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 2'd0, 16'h0000, 1'b0, 16'h0000, 2'd1, 16'd0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 2'd0, 16'h0000, 1'b0, 16'h13C7, 2'd1, 16'd0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 16'h12CF, 2'd3, 16'd0, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 16'h0000, 2'd0, 16'd0, 1'b1};
    vecs[18] = '{1'b1, 1'b1, 2'd0, 16'h0000, 1'b0, 16'h0000, 2'd1, 16'd0, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 2'd0, 16'h0000, 1'b0, 16'h13C7, 2'd1, 16'd0, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 16'h12CF, 2'd3, 16'd0, 1'b0};
    vecs[21] = '{1'b0, 1'b1, 2'd0, 16'h0000, 1'b0, 16'h33C6, 2'd1, 16'd0, 1'b0};
    vecs[22] = '{1'b0, 1'b1, 2'd0, 16'h0000, 1'b0, 16'h5B4C, 2'd1, 16'd0, 1'b0};
    vecs[23] = '{1'b0, 1'b1, 2'd0, 16'h0000, 1'b0, 16'h7FFF, 2'd2, 16'd0, 1'b0};

    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].rst_first) begin
        rst    = 1'b1;
        enable = 1'b0;
        @(negedge clk_216);
        check($sformatf("v%0d reset data_out", i), {16'h0, data_out}, 32'h0);
        check($sformatf("v%0d reset stb_out", i), 32'(stb_out), 32'h0);
        check($sformatf("v%0d reset state", i), 32'(state_o), 32'h0);
        check($sformatf("v%0d reset underflow", i), {16'h0, underflow_cnt}, 32'h0);
        rst = 1'b0;
      end
      enable    = vecs[i].en;
      src_sel   = vecs[i].src;
      ext_data  = vecs[i].xd;
      ext_valid = vecs[i].xv;
      wait_strobe(cyc, rdy_n, rdy_at);
      check($sformatf("v%0d strobe spacing", i), 32'(cyc), vecs[i].rst_first ? 32'd10 : 32'd8);
      check($sformatf("v%0d data_out", i), {16'h0, data_out}, {16'h0, vecs[i].exp_data});
      check($sformatf("v%0d state", i), 32'(state_o), 32'(vecs[i].exp_state));
      check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].exp_state != 2'd0));
      check($sformatf("v%0d underflow", i), {16'h0, underflow_cnt}, {16'h0, vecs[i].exp_uf});
      check($sformatf("v%0d ext_ready pulses", i), 32'(rdy_n), (vecs[i].src == 2'd1) ? 32'd1 : 32'd0);
      if (vecs[i].src == 2'd1)
        check($sformatf("v%0d ext_ready on tick", i), 32'(rdy_at), 32'(cyc - 2));
      if (vecs[i].idle_after) begin
        stb_seen = 0;
        repeat (24) begin
          @(negedge clk_216);
          if (stb_out) stb_seen++;
        end
        check($sformatf("v%0d no strobe in idle", i), 32'(stb_seen), 32'd0);
        check($sformatf("v%0d busy in idle", i), 32'(busy), 32'd0);
      end
    end

    // Mid-run reset with a sample sitting in stage 1
    repeat (6) @(negedge clk_216);
    check("hold data_out", {16'h0, data_out}, 32'h7FFF);
    check("hold stb_out", 32'(stb_out), 32'h0);
    @(negedge clk_216);
    rst = 1'b1;
    @(negedge clk_216);
    check("midrst stb_out", 32'(stb_out), 32'h0);
    check("midrst data_out", {16'h0, data_out}, 32'h0);
    check("midrst state", 32'(state_o), 32'h0);
    check("midrst underflow", {16'h0, underflow_cnt}, 32'h0);
    rst = 1'b0;
    @(negedge clk_216);
    check("midrst restart state", 32'(state_o), 32'd1);
    wait_strobe(cyc, rdy_n, rdy_at);
    check("midrst first strobe", 32'(cyc), 32'd9);
    check("midrst first data", {16'h0, data_out}, 32'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tx_audio_sequencer.md
Name: tx_audio_sequencer

Overview:
Controller that sequences the audio sample stream into the FM transmitter. It generates the audio-rate sample strobe from clk_216 and selects the sample source per strobe: internal 20-entry sine LUT, external handshaked stream, or mute. It applies a linear gain ramp on start/stop so the carrier never sees an amplitude step. Its data_out/stb_out drive the transmitter's data_in/stb_in directly.

Parameters:
WIDTH, 16, sample width (signed two's complement)
RATE, 4500, clk_216 cycles per sample strobe (216 MHz / 48 kHz)
RAMP_SHIFT, 8, ramp length = 2^RAMP_SHIFT strobes; full-scale gain = 2^RAMP_SHIFT

Ports:
clk_216  in  1  clock, 216 MHz
rst  in  1  reset, synchronous, active-high
enable  in  1  level; high = transmit audio, low = ramp down and idle
src_sel  in  2  0 = sine LUT, 1 = external stream, 2/3 = mute (zero)
ext_data  in  WIDTH  external sample
ext_valid  in  1  external sample available
ext_ready  out  1  external sample consumed this cycle (when ext_valid high)
data_out  out  WIDTH  scaled sample to transmitter
stb_out  out  1  one-cycle pulse, data_out valid
busy  out  1  state != IDLE
state_o  out  2  IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3
underflow_cnt  out  16  strobes with src_sel=1 and ext_valid low, saturating

Behaviour:
- Reset: state IDLE; gain 0; rate counter 0; LUT index 0; last external sample 0; data_out 0; stb_out 0; underflow_cnt 0.
- Rate counter: held at 0 in IDLE. Otherwise counts 0..RATE-1 and wraps. tick = (counter == RATE-1) and state != IDLE.
- IDLE -> RAMP_UP: on the cycle after enable is sampled high. Entering RAMP_UP from IDLE clears the LUT index and underflow_cnt.
- The gain register (RAMP_SHIFT+1 bits) updates only on tick:
  - RAMP_UP: gain+1; reaching 2^RAMP_SHIFT -> RUN.
  - RAMP_DOWN: gain-1; reaching 0 -> IDLE.
  - RUN: unchanged.
- Enable changes:
  - enable low in RAMP_UP or RUN -> RAMP_DOWN at the next cycle.
  - enable high in RAMP_DOWN -> RAMP_UP at the next cycle.
  - Gain continues from its current value in both cases; there are no jumps.
- Source selection on tick (src_sel sampled only at tick):
  - 0: sample = LUT[idx], then idx wraps 19 -> 0. LUT values are 0000,278E,4B3C,678D,79BB,7FFF,79BB,678D,4B3C,278E,0000,D872,B4C4,9873,8645,8001,8645,9873,B4C4,D872.
  - 1: ext_ready = tick (combinational, asserted only on tick cycles in non-IDLE states). If ext_valid, sample = ext_data, and last sample is updated. Otherwise sample = last sample and underflow_cnt increments, saturating at FFFF.
  - 2/3: sample = 0.
- Pipeline, with tick at cycle T:
  - T+1: stage 1 registers the sample and the post-update gain.
  - T+2: data_out = (sample * gain) >>> RAMP_SHIFT; stb_out = 1 for one cycle. Latency is 2 cycles.
- Arithmetic: signed WIDTH × unsigned (RAMP_SHIFT+1) product. The arithmetic shift floors toward minus infinity. The low WIDTH bits are the result. Gain ≤ 2^RAMP_SHIFT, so the result cannot overflow.
- The first RAMP_UP output uses gain 1. The last RAMP_DOWN output uses gain 0, and state is IDLE in the same cycle it is produced. Pipeline stages in flight still emit their stb_out after the transition to IDLE.
- data_out holds its last value between strobes.
- rst mid-operation: all registers return to reset values on the next edge. Any in-flight stb_out is dropped.

Test Plan:
1. RATE=8, RAMP_SHIFT=2, src_sel=0, enable high from cycle 0 -> first stb_out at cycle 10, then every 8 cycles. data_out sequence 0000, 13C7, 386D, 678D (state RUN after 4th tick), then 79BB, 7FFF unscaled.
2. Same config in RUN, drop enable -> 4 further strobes at gains 3, 2, 1, 0 (e.g. LUT 4B3C -> 386D ...). busy falls with the gain-0 tick. No stb_out after the in-flight samples drain.
3. src_sel=1, ext_valid high supplying 1234, then low at the next tick -> ext_ready pulses exactly on tick cycles. Second output repeats 1234 scaled. underflow_cnt = 1.
4. RATE=8, RAMP_SHIFT=2, src_sel=1, ext_data=8001, first tick (gain 1) -> data_out = E000 (floor of -8191.75).
5. enable low after 2nd RAMP_UP tick (gain 2) -> RAMP_DOWN. Next outputs use gains 1, 0, then IDLE. Re-raise enable during RAMP_DOWN at gain 1 -> gain goes 2, 3, 4, then RUN.
6. rst asserted for 1 cycle in RUN with a strobe in the pipeline -> next cycle: stb_out 0, data_out 0, state_o 0, underflow_cnt 0. With enable still high -> RAMP_UP on the following cycle.
